cpu_timing_ctrl: RTL

//  Run/stop/step controller for the 8-phase CPU timing ring. Owns the one-hot phase T[7:0]; advances
//  it only while running, ends each instruction early at a per-opcode last phase (T3/T5/T7), and

---
 rtl/cpu_timing_pkg.sv | 50 +++++
 rtl/cpu_timing_ctrl_phase_ring.sv | 37 +++
 rtl/cpu_timing_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cpu_timing_pkg.sv
// Shared definitions for the CPU timing controller.
//   state_t      controller states (idle / running / paused / halted)
//   T0..T7       one-hot phase constants, bit i = Ti
//   LEN_T3/5/7   possible last phases of an instruction
//   len_of_op    opcode -> one-hot last phase of that instruction
//   is_onehot    true when exactly one bit of an 8-bit phase vector is set
package cpu_timing_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [7:0] T0 = 8'b0000_0001;
    localparam logic [7:0] T1 = 8'b0000_0010;
    localparam logic [7:0] T2 = 8'b0000_0100;
    localparam logic [7:0] T3 = 8'b0000_1000;
    localparam logic [7:0] T4 = 8'b0001_0000;
    localparam logic [7:0] T5 = 8'b0010_0000;
    localparam logic [7:0] T6 = 8'b0100_0000;
    localparam logic [7:0] T7 = 8'b1000_0000;

    localparam logic [7:0] LEN_T3 = T3;
    localparam logic [7:0] LEN_T5 = T5;
    localparam logic [7:0] LEN_T7 = T7;

    localparam logic [3:0] HLT_OP_DEFAULT = 4'hF;

    // Opcode classes: 0-3 short (T3), 4-9 medium (T5), A-E long (T7),
    // F is the halt opcode and is short.
    function automatic logic [7:0] len_of_op(input logic [3:0] op);
        logic [7:0] len;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3:               len = LEN_T3;
            4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9:   len = LEN_T5;
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE:         len = LEN_T7;
            4'hF:                                 len = LEN_T3;
            default:                              len = LEN_T7;
        endcase
        return len;
    endfunction

    // Power-of-two test: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/cpu_timing_ctrl_phase_ring.sv
// 8-bit one-hot phase ring.
//   CLK      in   rising-edge clock
//   CLRn     in   asynchronous active-low reset, ring returns to T0
//   EN       in   advance the ring one phase (Ti -> Ti+1, T7 -> T0)
//   LOAD_T0  in   force the ring to T0 on the next edge (wins over EN)
//   T        out  current phase, registered
//   ERR      out  current phase is not one-hot
module cpu_timing_ctrl_phase_ring
    import cpu_timing_pkg::*;
(
    input  logic       CLK,
    input  logic       CLRn,
    input  logic       EN,
    input  logic       LOAD_T0,
    output logic [7:0] T,
    output logic       ERR
);

    logic [7:0] t_r;

    // Phase register: reload, rotate or hold.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            t_r <= T0;
        end else if (LOAD_T0) begin
            t_r <= T0;
        end else if (EN) begin
            t_r <= {t_r[6:0], t_r[7]};
        end else begin
            t_r <= t_r;
        end
    end

    assign T   = t_r;
    assign ERR = ~is_onehot(t_r);

endmodule

// File: rtl/cpu_timing_ctrl.sv
// Run/stop/step controller for the 8-phase CPU timing ring.
//   CLK        in   system clock
//   CLRn       in   asynchronous active-low reset
//   START      in   begin running (or one step when STEP_MODE=1)
//   STOP       in   stop at the end of the current instruction
//   STEP_MODE  in   pause after each instruction
//   STEP       in   release one instruction while paused
//   OP         in   opcode, sampled on the edge leaving T2
//   T          out  one-hot phase
//   RUN        out  ring is advancing
//   CYCLE_END  out  current phase is the last phase of the instruction
//   HALTED     out  halt opcode retired (sticky until reset)
//   PHASE_ERR  out  phase ring was seen not one-hot (sticky until reset)
//   INSTR_CNT  out  retired-instruction counter, wraps
module cpu_timing_ctrl
    import cpu_timing_pkg::*;
#(
    parameter int         CNT_W  = 16,
    parameter logic [3:0] HLT_OP = HLT_OP_DEFAULT
) (
    input  logic             CLK,
    input  logic             CLRn,
    input  logic             START,
    input  logic             STOP,
    input  logic             STEP_MODE,
    input  logic             STEP,
    input  logic [3:0]       OP,
    output logic [7:0]       T,
    output logic             RUN,
    output logic             CYCLE_END,
    output logic             HALTED,
    output logic             PHASE_ERR,
    output logic [CNT_W-1:0] INSTR_CNT
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       len_r;
    logic             hlt_r;
    logic             halted_r;
    logic             phase_err_r;
    logic [CNT_W-1:0] cnt_r;

    logic [7:0]       t_s;
    logic             ring_err_s;
    logic             run_s;
    logic             cycle_end_s;
    logic             latch_len_s;
    logic             load_t0_s;

    assign run_s       = (state_r == ST_RUN);
    // len_r is always T3/T5/T7, so T0..T2 can never match.
    assign cycle_end_s = run_s && (t_s == len_r);
    assign latch_len_s = run_s && (t_s == T2);
    assign load_t0_s   = ring_err_s || cycle_end_s;

    cpu_timing_ctrl_phase_ring u_ring (
        .CLK     (CLK),
        .CLRn    (CLRn),
        .EN      (run_s),
        .LOAD_T0 (load_t0_s),
        .T       (t_s),
        .ERR     (ring_err_s)
    );

    // Next-state decision for the run/stop/step controller.
    always_comb begin
        state_nxt_s = state_r;
        if (ring_err_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START && !STOP) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!cycle_end_s) begin
                        state_nxt_s = ST_RUN;
                    end else if (hlt_r) begin
                        state_nxt_s = ST_HALT;
                    end else if (STOP) begin
                        state_nxt_s = ST_IDLE;
                    end else if (STEP_MODE) begin
                        state_nxt_s = ST_PAUSE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (STOP) begin
                        state_nxt_s = ST_IDLE;
                    end else if (STEP) begin
                        state_nxt_s = ST_RUN;
                    end else if (!STEP_MODE && START) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_PAUSE;
                    end
                end
                ST_HALT: begin
                    state_nxt_s = ST_HALT;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Controller state register.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Instruction length and halt flag, captured as the ring leaves T2.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            len_r <= LEN_T7;
            hlt_r <= 1'b0;
        end else if (latch_len_s) begin
            len_r <= (OP == HLT_OP) ? LEN_T3 : len_of_op(OP);
            hlt_r <= (OP == HLT_OP);
        end else begin
            len_r <= len_r;
            hlt_r <= hlt_r;
        end
    end

    // Retired-instruction counter.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cycle_end_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky status flags: halt retired, phase ring corruption.
    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            halted_r    <= 1'b0;
            phase_err_r <= 1'b0;
        end else begin
            halted_r    <= halted_r || (cycle_end_s && hlt_r);
            phase_err_r <= phase_err_r || ring_err_s;
        end
    end

    assign T         = t_s;
    assign RUN       = run_s;
    assign CYCLE_END = cycle_end_s;
    assign HALTED    = halted_r;
    assign PHASE_ERR = phase_err_r;
    assign INSTR_CNT = cnt_r;

endmodule
